// File: rtl/icache_refill_ctrl_if.sv
// Fetch, memory-port and cache-array signals of the i-cache refill controller.
// Latency: none, signal bundle only.
// Backpressure: mem_ack is the only flow control; the controller holds mem_req/mem_addr until it arrives.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              hit;
  logic              branch_taken;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              cache_we;
  logic [ADDR_W-1:0] cache_waddr;
  logic [31:0]       cache_wdata;
  logic              tag_we;
  logic [ADDR_W-1:0] tag_addr;
  logic [31:0]       miss_count;

  // Controller side
  modport slave (
    input  fetch_valid, fetch_pc, hit, branch_taken, mem_ack, mem_rdata,
    output stall, mem_req, mem_addr, cache_we, cache_waddr, cache_wdata,
           tag_we, tag_addr, miss_count
  );

  // Fetch stage / memory / cache side
  modport master (
    output fetch_valid, fetch_pc, hit, branch_taken, mem_ack, mem_rdata,
    input  stall, mem_req, mem_addr, cache_we, cache_waddr, cache_wdata,
           tag_we, tag_addr, miss_count
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill controller: stalls fetch on a miss, burst-reads the line, writes words then tag/valid.
// Latency: miss stalls same cycle; LINE_WORDS+2 cycles minimum stall, +1 per memory wait cycle.
// Backpressure: each word request is held until mem_ack; ICACHE_MISS_CNT_EN adds a saturating refill counter.
module icache_refill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input logic                CLK,
  input logic                RST,
  icache_refill_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = CNT_W + 2;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  cnt;
  logic              miss;
  logic              last_word;
  logic              start;
  logic              word_ack;

  assign miss      = bus.fetch_valid && !bus.hit;
  assign last_word = (cnt == CNT_W'(LINE_WORDS - 1));
  assign start     = (state == IDLE) && miss;
  assign word_ack  = (state == REQ) && bus.mem_ack;

  // Redirects never abort a refill, and the in-line offset of the PC is irrelevant.
  logic unused_ok;
  assign unused_ok = ^{bus.branch_taken, bus.fetch_pc[OFF_W-1:0]};

  // Word address walks inside the line only; cnt wraps to 0 after the last word.
  assign bus.mem_addr = base + (ADDR_W'(cnt) << 2);
  assign bus.tag_addr = base;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and the state-decoded outputs
  always_comb begin
    state_nxt   = state;
    bus.mem_req = 1'b0;
    bus.tag_we  = 1'b0;
    bus.stall   = miss;
    case (state)
      IDLE: begin
        if (miss) state_nxt = REQ;
      end
      REQ: begin
        bus.mem_req = 1'b1;
        bus.stall   = 1'b1;
        if (bus.mem_ack && last_word) state_nxt = DONE;
      end
      DONE: begin
        bus.tag_we = 1'b1;
        bus.stall  = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line base latched on miss detection; word index advances on each accepted word
  always_ff @(posedge CLK) begin
    if (RST) begin
      base <= '0;
      cnt  <= '0;
    end else if (start) begin
      base <= {bus.fetch_pc[ADDR_W-1:OFF_W], OFF_W'(0)};
      cnt  <= '0;
    end else if (word_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Returned word is registered and written into the data array the following cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.cache_we    <= 1'b0;
      bus.cache_waddr <= '0;
      bus.cache_wdata <= '0;
    end else begin
      bus.cache_we <= word_ack;
      if (word_ack) begin
        bus.cache_waddr <= bus.mem_addr;
        bus.cache_wdata <= bus.mem_rdata;
      end
    end
  end

`ifdef ICACHE_MISS_CNT_EN
  logic [31:0] miss_cnt_q;

  // Count refill starts, saturating at all ones
  always_ff @(posedge CLK) begin
    if (RST)                                 miss_cnt_q <= '0;
    else if (start && (miss_cnt_q != '1))    miss_cnt_q <= miss_cnt_q + 32'd1;
  end

  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed scenarios plus randomized traffic vs a refill model.
module tb_icache_refill_ctrl;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam logic [31:0] OFF_MASK = 32'(LW * 4 - 1);

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  icache_refill_ctrl_if #(.ADDR_W(AW)) io ();
  icache_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (.CLK(CLK), .RST(RST), .bus(io));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: refill progress as "words received so far" -------------
  bit          m_act = 0;     // a refill is in flight (including its tag cycle)
  int          m_k = 0;       // words accepted so far in this refill
  logic [31:0] m_base = 0;
  bit          m_we = 0;
  logic [31:0] m_waddr = 0, m_wdata = 0, m_cnt = 0;
  bit          m_requesting, m_tagging;

  always @(posedge CLK) begin
    if (RST) begin
      m_act = 0; m_k = 0; m_base = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
    end else begin
      m_requesting = m_act && (m_k < LW);
      m_tagging    = m_act && (m_k == LW);
      m_we = 0;
      if (m_requesting && io.mem_ack) begin
        m_we = 1; m_waddr = m_base + 4 * m_k; m_wdata = io.mem_rdata; m_k++;
      end else if (m_tagging) begin
        m_act = 0;
      end else if (!m_act && io.fetch_valid && !io.hit) begin
        m_act = 1; m_base = io.fetch_pc & ~OFF_MASK; m_k = 0;
`ifdef ICACHE_MISS_CNT_EN
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
`endif
      end
    end
  end

  // ---------------- memory responder --------------------------------------------------------
  int wcnt = 0, wait_n = 0;
  bit rand_en = 0, stray_en = 0;

  always @(posedge CLK) begin
    #1;
    if (io.mem_req) begin
      if (wcnt >= wait_n) begin
        io.mem_ack   = 1'b1;
        io.mem_rdata = rand_en ? $urandom : 32'hA0 + ((io.mem_addr >> 2) & (LW - 1));
        wcnt = 0;
        if (rand_en) wait_n = $urandom_range(0, 2);
      end else begin
        io.mem_ack   = 1'b0;
        io.mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      io.mem_ack   = (stray_en || rand_en) ? 1'($urandom % 2) : 1'b0;
      io.mem_rdata = $urandom;
      wcnt = 0;
    end
  end

  // ---------------- per-cycle compare + observation log -------------------------------------
  bit chk_en = 0;
  int cyc = 0;
  int n_stall, n_we, n_tag, n_req;
  logic        lg_stall[64], lg_req[64], lg_we[64], lg_tag[64];
  logic [31:0] lg_addr[64], lg_taddr[64];
  logic [31:0] wa[16], wd[16];
  bit          e_req, e_tag;

  always @(negedge CLK) begin
    if (chk_en) begin
      e_req = m_act && (m_k < LW);
      e_tag = m_act && (m_k == LW);
      chk("stall", io.stall, m_act || (io.fetch_valid && !io.hit));
      chk("mem_req", io.mem_req, e_req);
      if (e_req) chk("mem_addr", io.mem_addr, m_base + 4 * m_k);
      chk("cache_we", io.cache_we, m_we);
      if (m_we) begin
        chk("cache_waddr", io.cache_waddr, m_waddr);
        chk("cache_wdata", io.cache_wdata, m_wdata);
      end
      chk("tag_we", io.tag_we, e_tag);
      if (e_tag) chk("tag_addr", io.tag_addr, m_base);
      chk("miss_count", io.miss_count, m_cnt);
    end
    if (cyc < 64) begin
      lg_stall[cyc] = io.stall; lg_req[cyc] = io.mem_req; lg_we[cyc] = io.cache_we;
      lg_tag[cyc] = io.tag_we; lg_addr[cyc] = io.mem_addr; lg_taddr[cyc] = io.tag_addr;
    end
    if (io.cache_we === 1'b1 && n_we < 16) begin
      wa[n_we] = io.cache_waddr; wd[n_we] = io.cache_wdata;
    end
    n_stall += int'(io.stall === 1'b1);
    n_we    += int'(io.cache_we === 1'b1);
    n_tag   += int'(io.tag_we === 1'b1);
    n_req   += int'(io.mem_req === 1'b1);
    cyc++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_test();
    n_stall = 0; n_we = 0; n_tag = 0; n_req = 0; cyc = 0;
  endtask

  task automatic drive(input bit fv, input bit h, input logic [31:0] pc, input bit br);
    io.fetch_valid = fv; io.hit = h; io.fetch_pc = pc; io.branch_taken = br;
  endtask

  logic [31:0] exp_cnt1;

  initial begin
`ifdef ICACHE_MISS_CNT_EN
    exp_cnt1 = 32'd1;
`else
    exp_cnt1 = 32'd0;
`endif
    RST = 1'b1;
    drive(0, 0, 32'h0, 0);
    repeat (2) step();
    @(negedge CLK);
    chk("rst_stall", io.stall, 1'b0);
    chk("rst_mem_req", io.mem_req, 1'b0);
    chk("rst_mem_addr", io.mem_addr, 32'h0);
    chk("rst_cache_we", io.cache_we, 1'b0);
    chk("rst_cache_waddr", io.cache_waddr, 32'h0);
    chk("rst_cache_wdata", io.cache_wdata, 32'h0);
    chk("rst_tag_we", io.tag_we, 1'b0);
    chk("rst_tag_addr", io.tag_addr, 32'h0);
    chk("rst_miss_count", io.miss_count, 32'h0);
    chk_en = 1;
    step();
    RST = 1'b0;

    // all hits: never stalls, never requests
    step(); drive(1, 1, 32'h100, 0); begin_test();
    repeat (10) step();
    chk("hit_stall_cycles", n_stall, 0);
    chk("hit_req_cycles", n_req, 0);
    chk("hit_miss_count", io.miss_count, 0);

    // zero-wait miss at 0x48
    wait_n = 0;
    step(); drive(1, 0, 32'h48, 0); begin_test();
    step(); drive(1, 1, 32'h48, 0);
    repeat (8) step();
    for (int i = 0; i < LW; i++) begin
      chk("zw_mem_req", lg_req[i+1], 1'b1);
      chk("zw_mem_addr", lg_addr[i+1], 32'h40 + 4 * i);
      chk("zw_waddr", wa[i], 32'h40 + 4 * i);
      chk("zw_wdata", wd[i], 32'hA0 + i);
    end
    chk("zw_we_c2", lg_we[2], 1'b1);
    chk("zw_tag_c5", lg_tag[5], 1'b1);
    chk("zw_tag_addr", lg_taddr[5], 32'h40);
    chk("zw_tag_pulses", n_tag, 1);
    chk("zw_we_pulses", n_we, 4);
    chk("zw_stall_cycles", n_stall, 6);
    chk("zw_stall_c6", lg_stall[6], 1'b0);
    chk("zw_miss_count", io.miss_count, exp_cnt1);

    // three wait cycles per word
    wait_n = 3;
    step(); drive(1, 0, 32'h1C4, 0); begin_test();
    step(); drive(1, 1, 32'h1C4, 0);
    repeat (22) step();
    for (int c = 1; c <= 16; c++) chk("w3_addr_hold", lg_addr[c], 32'h1C0 + 4 * ((c - 1) / 4));
    chk("w3_stall_cycles", n_stall, 18);
    chk("w3_we_pulses", n_we, 4);
    chk("w3_tag_c17", lg_tag[17], 1'b1);
    wait_n = 0;

    // branch redirect during word 2, new PC misses right away
    step(); drive(1, 0, 32'h48, 0); begin_test();
    step();
    step(); drive(1, 0, 32'h208, 1);
    step(); drive(1, 0, 32'h208, 0);
    repeat (4) step();
    drive(1, 1, 32'h208, 0);
    repeat (10) step();
    chk("br_tag_c5", lg_tag[5], 1'b1);
    chk("br_tag_addr", lg_taddr[5], 32'h40);
    chk("br_last_waddr", wa[3], 32'h4C);
    chk("br_req_c6", lg_req[6], 1'b0);
    chk("br_stall_c6", lg_stall[6], 1'b1);
    chk("br_req_c7", lg_req[7], 1'b1);
    chk("br_addr_c7", lg_addr[7], 32'h200);
    chk("br_tag_pulses", n_tag, 2);
    chk("br_we_pulses", n_we, 8);

    // reset in the middle of a refill
    step(); drive(1, 0, 32'h88, 0); begin_test();
    step(); drive(1, 1, 32'h88, 0);
    step();
    step(); RST = 1'b1;
    step(); RST = 1'b0; drive(0, 0, 32'h88, 0);
    repeat (6) step();
    chk("rst_mid_req_c4", lg_req[4], 1'b0);
    chk("rst_mid_stall_c4", lg_stall[4], 1'b0);
    chk("rst_mid_we_c4", lg_we[4], 1'b0);
    chk("rst_mid_we_pulses", n_we, 2);
    chk("rst_mid_tag_pulses", n_tag, 0);
    chk("rst_mid_miss_count", io.miss_count, 32'h0);

    // stray acks while idle
    stray_en = 1;
    step(); drive(0, 1, 32'h300, 0); begin_test();
    repeat (12) step();
    chk("stray_we_pulses", n_we, 0);
    chk("stray_req_cycles", n_req, 0);
    chk("stray_stall_cycles", n_stall, 0);
    stray_en = 0;

    // randomized traffic against the model
    rand_en = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      RST = ($urandom_range(0, 299) == 0);
      drive(($urandom % 4) != 0, ($urandom % 5) != 0, {$urandom, 2'b00} & 32'h0000_FFFC, ($urandom % 8) == 0);
    end
    rand_en = 0;
    RST = 1'b0;
    drive(0, 1, 32'h0, 0);
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
